// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH        default operand width (result is 2*WIDTH)
//   mdu_op_e     operation select as driven by the control unit
//   mdu_state_e  sequencing states of the unit
package mul_div_unit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the shared multiply/divide datapath (purely combinational).
//   op_i          OP_MUL: radix-2 Booth step, OP_DIV: restoring-divide step
//   acc_i/acc_o   MUL: upper partial product (W+1 bits, signed)
//                 DIV: partial remainder (always < divisor, so top bit stays 0)
//   q_i/q_o       MUL: multiplier being shifted out / product low half
//                 DIV: dividend being shifted out / quotient shifted in
//   qm1_i/qm1_o   Booth q(-1) bit (passes through in DIV)
//   m_i           MUL: sign-extended multiplicand, DIV: divisor magnitude
module mul_div_unit_step
  import mul_div_unit_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  mdu_op_e      op_i,
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] q_i,
  input  logic         qm1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] q_o,
  output logic         qm1_o
);

  logic [W:0]   sum;
  logic [W:0]   trial;
  logic [W+1:0] diff;

  always_comb begin
    acc_o = acc_i;
    q_o   = q_i;
    qm1_o = qm1_i;
    sum   = '0;
    trial = '0;
    diff  = '0;
    if (op_i == OP_MUL) begin
      unique case ({q_i[0], qm1_i})
        2'b10:   sum = acc_i - m_i;
        2'b01:   sum = acc_i + m_i;
        default: sum = acc_i;
      endcase
      // Arithmetic shift right of {acc, q, q-1}; W+1 bit acc keeps
      // acc +/- m exact even for the most negative multiplicand.
      {acc_o, q_o, qm1_o} = {sum[W], sum, q_i};
    end else begin
      trial = {acc_i[W-1:0], q_i[W-1]};
      diff  = {1'b0, trial} - {1'b0, m_i};
      if (!diff[W+1]) begin
        acc_o = diff[W:0];
        q_o   = {q_i[W-2:0], 1'b1};
      end else begin
        acc_o = trial;
        q_o   = {q_i[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed WxW multiplier / W/W divider with fixed latency.
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    request, sampled only in IDLE
//   op_i       0 = MUL, 1 = DIV (sampled with start_i)
//   a_i, b_i   multiplicand/dividend, multiplier/divisor (two's complement)
//   busy_o     high from the cycle after accept through the done cycle
//   done_o     one-cycle pulse, result valid
//   result_o   MUL: signed product; DIV: {remainder, quotient}
//   dbz_o      divide-by-zero flag, held with result_o
//
// state   | meaning
// IDLE    | waiting for start_i
// RUN     | one datapath iteration per cycle, counter W-1 down to 0
// FIX     | sign correction / special cases, result register written
// DONE    | done pulse, then back to IDLE
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] result_o,
  output logic           dbz_o
);

  localparam int CW = $clog2(W);

  mdu_state_e     state_q;
  mdu_op_e        op_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   qr_q, qr_d;
  logic           qm1_q, qm1_d;
  logic [W:0]     m_q;
  logic [W-1:0]   a_q;
  logic           b_zero_q;
  logic           neg_quot_q;
  logic           neg_rem_q;
  logic           busy_q;
  logic           done_q;
  logic [2*W-1:0] result_q, result_d;
  logic           dbz_q, dbz_d;

  logic [W-1:0]   quot;
  logic [W-1:0]   rem;

  // Magnitude of the most negative value is 2^(W-1), which is exact as unsigned.
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  mul_div_unit_step #(.W(W)) u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .q_i   (qr_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (acc_d),
    .q_o   (qr_d),
    .qm1_o (qm1_d)
  );

  always_comb begin
    quot     = neg_quot_q ? -qr_q : qr_q;
    rem      = neg_rem_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    result_d = '0;
    dbz_d    = 1'b0;
    if (op_q == OP_MUL) begin
      result_d = {acc_q[W-1:0], qr_q};
    end else if (b_zero_q) begin
      result_d = {a_q, {W{1'b1}}};
      dbz_d    = 1'b1;
    end else begin
      // min / -1 falls out naturally: quotient 2^(W-1) negated wraps to itself.
      result_d = {rem, quot};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_MUL;
      cnt_q      <= '0;
      acc_q      <= '0;
      qr_q       <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      a_q        <= '0;
      b_zero_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dbz_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(W - 1);
            op_q       <= mdu_op_e'(op_i);
            a_q        <= a_i;
            b_zero_q   <= (b_i == '0);
            neg_quot_q <= a_i[W-1] ^ b_i[W-1];
            neg_rem_q  <= a_i[W-1];
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            if (mdu_op_e'(op_i) == OP_DIV) begin
              m_q  <= {1'b0, abs_val(b_i)};
              qr_q <= abs_val(a_i);
            end else begin
              m_q  <= {a_i[W-1], a_i};
              qr_q <= b_i;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          qr_q  <= qr_d;
          qm1_q <= qm1_d;
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIX: begin
          result_q <= result_d;
          dbz_q    <= dbz_d;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        dbz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .dbz_o    (dbz)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Launches one operation and waits (bounded) for done; returns in the done cycle.
  task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic op_v, input logic [31:0] a_v,
                               input logic [31:0] b_v, input logic [63:0] exp_res,
                               input logic exp_dbz);
    int lat;
    int bc;
    run_op(op_v, a_v, b_v, lat, bc);
    check_val({tag, " result"}, result, exp_res);
    check_val({tag, " dbz"}, 64'(dbz), 64'(exp_dbz));
    check_val({tag, " latency"}, 64'(lat), 64'd34);
    check_val({tag, " busy cycles"}, 64'(bc), 64'd34);
    @(negedge clk);
    check_val({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [63:0] ref_result(input logic op_v, input logic [31:0] a_v,
                                             input logic [31:0] b_v);
    longint sa;
    longint sb;
    longint qv;
    longint rv;
    logic [63:0] qb;
    logic [63:0] rb;
    sa = longint'($signed(a_v));
    sb = longint'($signed(b_v));
    if (!op_v) return 64'(sa * sb);
    if (b_v == 32'd0) return {a_v, 32'hFFFF_FFFF};
    qv = sa / sb;
    rv = sa % sb;
    qb = qv;
    rb = rv;
    return {rb[31:0], qb[31:0]};
  endfunction

  initial begin
    int lat;
    int bc;
    int done_cnt;
    logic [63:0] res_seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rop;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_val("reset outputs", {result[61:0], busy, done} | {63'd0, dbz}, 64'd0);
    check_val("reset result", result, 64'd0);
    rst_n = 1'b1;

    run_and_check("mul 7*-3",      1'b0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_and_check("div -7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_and_check("div 7/-2",      1'b1, 32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0);
    run_and_check("div 100/7",     1'b1, 32'd100,        32'd7,         64'h0000_0002_0000_000E, 1'b0);
    run_and_check("div -100/7",    1'b1, 32'hFFFF_FF9C,  32'd7,         64'hFFFF_FFFE_FFFF_FFF2, 1'b0);
    run_and_check("div 5/0",       1'b1, 32'd5,          32'd0,         64'h0000_0005_FFFF_FFFF, 1'b1);
    run_and_check("mul 0*5",       1'b0, 32'd0,          32'd5,         64'h0000_0000_0000_0000, 1'b0);
    run_and_check("div min/-1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_and_check("div min/1",     1'b1, 32'h8000_0000,  32'd1,         64'h0000_0000_8000_0000, 1'b0);
    run_and_check("mul min*min",   1'b0, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_and_check("mul max*min",   1'b0, 32'h7FFF_FFFF,  32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0);
    run_and_check("mul max*max",   1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
    run_and_check("mul -1*-1",     1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);

    // Extra start pulses while busy (RUN, FIX, DONE) must be ignored.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd6;
    b     = 32'd7;
    done_cnt = 0;
    res_seen = '0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        res_seen = result;
      end
      if (c == 5 || c == 33 || c == 34) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd9;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    check_val("ignore start done count", 64'(done_cnt), 64'd1);
    check_val("ignore start result", res_seen, 64'd42);
    check_val("ignore start no relaunch", 64'(busy), 64'd0);
    check_val("ignore start held result", result, 64'd42);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid reset busy/done/dbz", {61'd0, busy, done, dbz}, 64'd0);
    check_val("mid reset result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("no done after abort", 64'(done_cnt), 64'd0);
    run_and_check("mul 3*4 after reset", 1'b0, 32'd3, 32'd4, 64'd12, 1'b0);

    // Random pairs against a signed reference model.
    for (int i = 0; i < 40; i++) begin
      rop = i[0];
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, lat, bc);
      check_val(rop ? "rand div result" : "rand mul result", result, ref_result(rop, ra, rb));
      check_val("rand dbz", 64'(dbz), 64'(rop && rb == 32'd0));
      check_val("rand latency", 64'(lat), 64'd34);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
